// File: rtl/quantum_scheduler_if.sv
// Scheduler <-> CPU control-unit signal bundle.
// master: CPU control unit side, slave: quantum_scheduler side.
interface quantum_scheduler_if #(
   parameter int PID_W     = 3,
   parameter int QUANTUM_W = 16
);
   logic                 stop;
   logic                 quantum_load;
   logic [QUANTUM_W-1:0] quantum_value;
   logic                 proc_add;
   logic [PID_W-1:0]     proc_add_id;
   logic                 proc_kill;
   logic [PID_W-1:0]     proc_kill_id;
   logic                 yield;
   logic                 switch_ack;
   logic                 switch_done;
   logic                 sigint;
   logic [PID_W-1:0]     next_pid;
   logic                 next_valid;
   logic [PID_W-1:0]     cur_pid;
   logic                 idle;
   logic                 sched_err;

   modport master (
      output stop, quantum_load, quantum_value, proc_add, proc_add_id,
             proc_kill, proc_kill_id, yield, switch_ack, switch_done,
      input  sigint, next_pid, next_valid, cur_pid, idle, sched_err
   );

   modport slave (
      input  stop, quantum_load, quantum_value, proc_add, proc_add_id,
             proc_kill, proc_kill_id, yield, switch_ack, switch_done,
      output sigint, next_pid, next_valid, cur_pid, idle, sched_err
   );
endinterface

// File: rtl/quantum_scheduler.sv
// Round-robin process scheduler: ready mask, quantum timer, preemption
// interrupt and save/dispatch/restore handshake sequencing.
// Optional feature: define SCHED_WATCHDOG_EN to enable an 8-bit handshake
// timeout in IRQ/DISPATCH that sets the sticky sched_err flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no process running, waiting for a nonzero ready mask
// SELECT   | one-cycle round-robin search starting after cur_pid
// DISPATCH | next_pid offered to CPU, waiting for switch_done
// RUN      | cur_pid owns the CPU, quantum counter running
// IRQ      | sigint raised, waiting for switch_ack (context saved)
module quantum_scheduler #(
   parameter int NPROC           = 8,
   parameter int PID_W           = 3,
   parameter int QUANTUM_W       = 16,
   parameter int QUANTUM_DEFAULT = 5000
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   quantum_scheduler_if.slave  sched_if
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SELECT   = 3'd1;
   localparam logic [2:0] ST_DISPATCH = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_IRQ      = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [NPROC-1:0]     ready_q, ready_d;
   logic [QUANTUM_W-1:0] quantum_q, quantum_d;
   logic [QUANTUM_W-1:0] counter_q, counter_d;
   logic                 sigint_q, sigint_d;
   logic [PID_W-1:0]     next_pid_q, next_pid_d;
   logic                 next_valid_q, next_valid_d;
   logic [PID_W-1:0]     cur_pid_q, cur_pid_d;
   logic                 idle_q, idle_d;

   logic                 found;
   logic [PID_W-1:0]     sel_pid;
   int                   idx;
   logic                 add_ok, kill_ok, kill_cur, expire;

`ifdef SCHED_WATCHDOG_EN
   logic [7:0]           wdog_q, wdog_d;
   logic                 err_q, err_d;
`endif

   // Out-of-range slot ids are dropped; kill of the running process is special.
   always_comb begin
      add_ok   = sched_if.proc_add  && (int'(sched_if.proc_add_id)  < NPROC);
      kill_ok  = sched_if.proc_kill && (int'(sched_if.proc_kill_id) < NPROC);
      kill_cur = kill_ok && (sched_if.proc_kill_id == cur_pid_q);
      expire   = (quantum_q != '0) && (counter_q == quantum_q - QUANTUM_W'(1));
   end

   // Round-robin search: cur_pid+1 upward with wrap, cur_pid examined last.
   always_comb begin
      found   = 1'b0;
      sel_pid = '0;
      idx     = 0;
      for (int i = 1; i <= NPROC; i++) begin
         idx = (int'(cur_pid_q) + i) % NPROC;
         if (!found && ready_q[PID_W'(idx)]) begin
            found   = 1'b1;
            sel_pid = PID_W'(idx);
         end
      end
   end

   // Next-state logic for the FSM, ready mask, quantum and counter.
   always_comb begin
      state_d      = state_q;
      ready_d      = ready_q;
      quantum_d    = quantum_q;
      counter_d    = counter_q;
      sigint_d     = sigint_q;
      next_pid_d   = next_pid_q;
      next_valid_d = next_valid_q;
      cur_pid_d    = cur_pid_q;
      idle_d       = idle_q;
`ifdef SCHED_WATCHDOG_EN
      wdog_d       = '0;
      err_d        = err_q;
`endif

      if (sched_if.quantum_load) quantum_d = sched_if.quantum_value;

      case (state_q)
         ST_IDLE: begin
            idle_d = 1'b1;
            if (|ready_q) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (found) begin
               next_pid_d   = sel_pid;
               next_valid_d = 1'b1;
               state_d      = ST_DISPATCH;
            end else begin
               idle_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DISPATCH: begin
            if (sched_if.switch_done) begin
               cur_pid_d    = next_pid_q;
               next_valid_d = 1'b0;
               idle_d       = 1'b0;
               counter_d    = '0;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            // A killed process has no context worth saving, so skip IRQ.
            if (kill_cur) begin
               state_d = ST_SELECT;
            end else if (sched_if.yield || (!sched_if.stop && expire)) begin
               sigint_d = 1'b1;
               state_d  = ST_IRQ;
            end else if (!sched_if.stop) begin
               counter_d = counter_q + QUANTUM_W'(1);
            end
         end
         ST_IRQ: begin
            if (kill_cur || sched_if.switch_ack) begin
               sigint_d = 1'b0;
               state_d  = ST_SELECT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (add_ok)  ready_d[sched_if.proc_add_id]  = 1'b1;
      if (kill_ok) ready_d[sched_if.proc_kill_id] = 1'b0;

`ifdef SCHED_WATCHDOG_EN
      // 255 consecutive cycles without ack/done: abandon the handshake and
      // retire the offending process.
      if ((state_q == ST_IRQ && !sched_if.switch_ack && !kill_cur) ||
          (state_q == ST_DISPATCH && !sched_if.switch_done)) begin
         if (wdog_q == 8'd254) begin
            err_d              = 1'b1;
            sigint_d           = 1'b0;
            next_valid_d       = 1'b0;
            ready_d[cur_pid_q] = 1'b0;
            state_d            = ST_SELECT;
         end else begin
            wdog_d = wdog_q + 8'd1;
         end
      end
`endif
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         ready_q      <= '0;
         quantum_q    <= QUANTUM_W'(QUANTUM_DEFAULT);
         counter_q    <= '0;
         sigint_q     <= 1'b0;
         next_pid_q   <= '0;
         next_valid_q <= 1'b0;
         cur_pid_q    <= '0;
         idle_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         quantum_q    <= quantum_d;
         counter_q    <= counter_d;
         sigint_q     <= sigint_d;
         next_pid_q   <= next_pid_d;
         next_valid_q <= next_valid_d;
         cur_pid_q    <= cur_pid_d;
         idle_q       <= idle_d;
      end
   end

`ifdef SCHED_WATCHDOG_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign sched_if.sched_err = err_q;
`else
   assign sched_if.sched_err = 1'b0;
`endif

   assign sched_if.sigint     = sigint_q;
   assign sched_if.next_pid   = next_pid_q;
   assign sched_if.next_valid = next_valid_q;
   assign sched_if.cur_pid    = cur_pid_q;
   assign sched_if.idle       = idle_q;

endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Round-robin process scheduler for the processor's time-sharing support. Keeps a ready mask of up to NPROC process slots, counts a programmable quantum for the running process, raises a preemption interrupt to the CPU on expiry, and sequences the save/dispatch/restore handshake that hands the CPU to the next ready process. It sits beside the CPU control unit and replaces a free-running interrupt timer with a scheduler that knows which process runs next.

## Interface
- NPROC, 8: number of process slots (2..16).
- PID_W, 3: width of process IDs; 2^PID_W >= NPROC.
- QUANTUM_W, 16: quantum counter width.
- QUANTUM_DEFAULT, 5000: quantum loaded at reset.
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stop  in  1  freezes the quantum counter (CPU halted or in a critical section).
- quantum_load  in  1  loads quantum_value into the quantum register.
- quantum_value  in  QUANTUM_W  new quantum; 0 means preemption disabled.
- proc_add  in  1  set ready bit of proc_add_id.
- proc_add_id  in  PID_W  slot to add.
- proc_kill  in  1  clear ready bit of proc_kill_id.
- proc_kill_id  in  PID_W  slot to remove.
- yield  in  1  running process gives up the CPU (RUN only).
- switch_ack  in  1  CPU has saved the current context.
- switch_done  in  1  CPU has restored the context of next_pid.
- sigint  out  1  preemption request to CPU.
- next_pid  out  PID_W  process selected for dispatch.
- next_valid  out  1  next_pid valid, held until switch_done.
- cur_pid  out  PID_W  process currently owning the CPU.
- idle  out  1  no process running.
- sched_err  out  1  sticky handshake-timeout flag (see Configuration).

## Operation
- States: IDLE, SELECT, DISPATCH, RUN, IRQ.
- Reset: state IDLE, ready mask 0, quantum = QUANTUM_DEFAULT, counter 0, sigint 0, next_valid 0, next_pid 0, cur_pid 0, idle 1, sched_err 0.
- Ready mask: add/kill accepted in every state; same id added and killed in one cycle -> kill wins; ids >= NPROC ignored.
- IDLE: idle=1; when ready mask nonzero -> SELECT.
- SELECT (one cycle): search from cur_pid+1 upward, wrap to 0, cur_pid checked last. Found -> latch next_pid, next_valid=1, DISPATCH. None -> IDLE.
- DISPATCH: next_valid held; on switch_done -> cur_pid=next_pid, next_valid=0, idle=0, counter=0, RUN.
- RUN: counter increments each cycle with stop=0. counter==quantum-1 with stop=0, or yield=1 -> IRQ. quantum=0: never expires. Kill of cur_pid -> SELECT directly (no save).
- IRQ: sigint=1; on switch_ack -> sigint=0, SELECT. Kill of cur_pid during IRQ -> sigint=0, SELECT.
- Only ready process is cur_pid: re-selected, full handshake still performed.
- quantum_load takes effect on the next counter comparison; counter not cleared.

## Timing
- sigint, next_valid, idle, cur_pid are registered.
- Quantum Q: sigint rises Q counted cycles after the RUN-entry edge (stalled cycles excluded).
- yield in RUN -> sigint next cycle.
- switch_ack -> next_valid rises 2 cycles later (IRQ->SELECT->DISPATCH).
- switch_done -> cur_pid updates and counting starts next cycle.
- switch_ack outside IRQ and switch_done outside DISPATCH ignored.
- reset assertion mid-handshake forces reset values immediately, asynchronously.

## Configuration
- SCHED_WATCHDOG_EN defined: 8-bit timeout counter runs in IRQ and DISPATCH; 255 cycles without the expected ack/done -> sched_err=1 (sticky until reset), sigint/next_valid dropped, cur_pid's ready bit cleared, state SELECT.
- Undefined: no timeout, FSM waits indefinitely; sched_err tied 0.

## Test plan
- Reset, add pids 2 and 5, quantum 10 -> next_pid=2; after switch_done sigint rises 10 cycles later; after ack next_pid=5, then 2 again (wrap).
- Quantum 8, stop high for 4 cycles mid-RUN -> sigint rises 12 cycles after RUN entry.
- Only pid 3 ready, yield -> sigint next cycle; after ack next_pid=3.
- Kill cur_pid 1 in RUN with pid 4 ready -> no sigint, next_pid=4 two cycles later; kill last process -> idle=1.
- Add and kill pid 6 same cycle -> ready bit stays 0; quantum_value 0 -> no sigint over 100k cycles.
- With SCHED_WATCHDOG_EN, withhold switch_ack -> after 255 cycles sched_err=1, sigint=0, next process dispatched.
